// File: rtl/boolean_bb_pkg.sv
// Shared types and truth-table constants for the boolean_bb_unit block.
// Optional hit counter in the top is enabled by BOOLEAN_BB_HITCNT_EN.
package boolean_bb_pkg;

  localparam int TT_WIDTH  = 8;
  localparam int IDX_WIDTH = 3;

  typedef logic [TT_WIDTH-1:0] tt_t;

  localparam tt_t TT_MAJ  = 8'hE8;
  localparam tt_t TT_AND3 = 8'h80;
  localparam tt_t TT_OR3  = 8'hFE;
  localparam tt_t TT_XOR3 = 8'h96;

endpackage

// File: rtl/boolean_bb_lut8.sv
// Pure combinational 8:1 truth-table mux.
// Shared by the live and registered result paths.
module boolean_bb_lut8
  import boolean_bb_pkg::*;
(
  input  tt_t                  tt,
  input  logic [IDX_WIDTH-1:0] idx,
  output logic                 out
);

  assign out = tt[idx];

endmodule

// File: rtl/boolean_bb_unit.sv
// Programmable 3-input Boolean evaluator with run-time table reload.
// Define BOOLEAN_BB_HITCNT_EN to add the saturating hit_cnt output.
module boolean_bb_unit
  import boolean_bb_pkg::*;
#(
  parameter tt_t TT_INIT = TT_MAJ,
  parameter int  REG_OUT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a,
  input  logic                 b,
  input  logic                 c,
  input  logic                 cfg_we,
  input  tt_t                  cfg_tt,
  output logic                 d,
  output logic                 d_comb,
`ifdef BOOLEAN_BB_HITCNT_EN
  output logic [15:0]          hit_cnt,
`endif
  output logic [IDX_WIDTH-1:0] idx,
  output logic                 d_chg,
  output tt_t                  tt
);

  logic [IDX_WIDTH-1:0] idx_now;
  logic                 d_reg;

  assign idx_now = {a, b, c};

  boolean_bb_lut8 u_lut (
    .tt  (tt),
    .idx (idx_now),
    .out (d_comb)
  );

  // Evaluation uses the table as it stands before a same-edge write.
  always_ff @(posedge clk) begin
    if (rst) begin
      tt    <= TT_INIT;
      d_reg <= 1'b0;
      idx   <= '0;
      d_chg <= 1'b0;
    end else begin
      if (cfg_we)
        tt <= cfg_tt;
      d_reg <= d_comb;
      idx   <= idx_now;
      d_chg <= d_comb ^ d_reg;
    end
  end

  assign d = (REG_OUT != 0) ? d_reg : d_comb;

`ifdef BOOLEAN_BB_HITCNT_EN
  // Counts edges that load a 1 into d_reg, i.e. cycles with d_reg high.
  always_ff @(posedge clk) begin
    if (rst || cfg_we)
      hit_cnt <= '0;
    else if (d_comb && hit_cnt != 16'hFFFF)
      hit_cnt <= hit_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_boolean_bb_unit.sv
// Directed self-checking bench for boolean_bb_unit.
// Covers hit_cnt when BOOLEAN_BB_HITCNT_EN is defined.
module tb_boolean_bb_unit;
  import boolean_bb_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       a, b, c;
  logic       cfg_we;
  tt_t        cfg_tt;
  logic       d, d_comb, d_chg;
  logic [2:0] idx;
  tt_t        tt;
`ifdef BOOLEAN_BB_HITCNT_EN
  logic [15:0] hit_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic exp_maj [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic exp_xor [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  boolean_bb_unit dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .c       (c),
    .cfg_we  (cfg_we),
    .cfg_tt  (cfg_tt),
    .d       (d),
    .d_comb  (d_comb),
`ifdef BOOLEAN_BB_HITCNT_EN
    .hit_cnt (hit_cnt),
`endif
    .idx     (idx),
    .d_chg   (d_chg),
    .tt      (tt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [2:0] v);
    {a, b, c} = v;
  endtask

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    cfg_we = 1'b0;
    cfg_tt = 8'h00;
    set_in(3'b011);
    tick();
    tick();
    check("rst_tt", 16'(tt), 16'h00E8);
    check("rst_d", 16'(d), 16'h0);
    check("rst_idx", 16'(idx), 16'h0);
    check("rst_chg", 16'(d_chg), 16'h0);
    check("rst_dcomb", 16'(d_comb), 16'h1);

    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_in(3'(i));
      tick();
      check($sformatf("maj_d%0d", i), 16'(d), 16'(exp_maj[i]));
      check($sformatf("maj_idx%0d", i), 16'(idx), 16'(i));
      tick();
      check($sformatf("maj_hold%0d", i), 16'(d), 16'(exp_maj[i]));
    end

    // Write XOR while evaluating 011: old majority table still applies.
    set_in(3'b011);
    cfg_we = 1'b1;
    cfg_tt = TT_XOR3;
    tick();
    cfg_we = 1'b0;
    check("wr_old_d", 16'(d), 16'h1);
    check("wr_tt", 16'(tt), 16'h0096);
    check("wr_dcomb", 16'(d_comb), 16'h0);
    tick();
    check("wr_new_d", 16'(d), 16'h0);
    for (int i = 0; i < 8; i++) begin
      set_in(3'(i));
      tick();
      check($sformatf("xor_d%0d", i), 16'(d), 16'(exp_xor[i]));
      tick();
    end

    // Back to majority with d settled at 1 on input 111.
    cfg_we = 1'b1;
    cfg_tt = TT_MAJ;
    tick();
    cfg_we = 1'b0;
    tick();
    check("pre_col_d", 16'(d), 16'h1);

    // Collision: 011 with a write of 00 on the same edge.
    set_in(3'b011);
    cfg_we = 1'b1;
    cfg_tt = 8'h00;
    tick();
    cfg_we = 1'b0;
    check("col_d1", 16'(d), 16'h1);
    check("col_chg1", 16'(d_chg), 16'h0);
    tick();
    check("col_d2", 16'(d), 16'h0);
    check("col_chg2", 16'(d_chg), 16'h1);
    tick();
    check("col_chg3", 16'(d_chg), 16'h0);

    // Mid-operation reset overrides a loaded AND3 table.
    cfg_we = 1'b1;
    cfg_tt = TT_AND3;
    tick();
    cfg_we = 1'b0;
    check("and_tt", 16'(tt), 16'h0080);
    set_in(3'b111);
    tick();
    check("and_d", 16'(d), 16'h1);
    rst = 1'b1;
    cfg_we = 1'b1;
    cfg_tt = TT_OR3;
    tick();
    rst = 1'b0;
    cfg_we = 1'b0;
    check("mrst_tt", 16'(tt), 16'h00E8);
    check("mrst_d", 16'(d), 16'h0);
    check("mrst_chg", 16'(d_chg), 16'h0);
    tick();
    check("mrst_d1", 16'(d), 16'h1);

    // Change pulse sequence 000 -> 111 -> 111 -> 000.
    set_in(3'b000);
    tick();
    tick();
    check("chg_base", 16'(d), 16'h0);
    set_in(3'b111);
    tick();
    check("chg_up_d", 16'(d), 16'h1);
    check("chg_up", 16'(d_chg), 16'h1);
    tick();
    check("chg_hold", 16'(d_chg), 16'h0);
    set_in(3'b000);
    tick();
    check("chg_dn_d", 16'(d), 16'h0);
    check("chg_dn", 16'(d_chg), 16'h1);

`ifdef BOOLEAN_BB_HITCNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("hit_rst", hit_cnt, 16'd0);
    set_in(3'b111);
    repeat (5) tick();
    check("hit_5", hit_cnt, 16'd5);
    cfg_we = 1'b1;
    cfg_tt = TT_MAJ;
    tick();
    cfg_we = 1'b0;
    check("hit_clr", hit_cnt, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
